// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports and memory bus of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;
  logic [15:0]       conflict_cnt_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, conflict_cnt_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, conflict_cnt_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one fixed-latency memory between IF and MEM
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q;
  logic [3:0]        lat_cnt_q;
  logic              last_dm_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [15:0]       conflict_cnt_q;
  logic [15:0]       conflict_cnt_d;

  // DM wins when it is the only requester or when IF was served last.
  logic grant_dm;
  assign grant_dm = bus.dm_req_i && (!bus.if_req_i || !last_dm_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      last_dm_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we_i;
            mem_addr_q  <= bus.dm_addr_i;
            mem_wdata_q <= bus.dm_wdata_i;
            last_dm_q   <= 1'b1;
            lat_cnt_q   <= LAT_INIT;
            state_q     <= BUSY_DM;
          end else if (bus.if_req_i) begin
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr_i;
            last_dm_q  <= 1'b0;
            lat_cnt_q  <= LAT_INIT;
            state_q    <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (lat_cnt_q == 4'd0) begin
            if_rdata_q <= bus.mem_rdata_i;
            if_ack_q   <= 1'b1;
            state_q    <= IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        BUSY_DM: begin
          if (lat_cnt_q == 4'd0) begin
            // mem_we_q still holds this transaction's direction; stores leave load data alone.
            if (!mem_we_q) dm_rdata_q <= bus.mem_rdata_i;
            dm_ack_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (bus.if_req_i && bus.dm_req_i && !if_ack_q && !dm_ack_q && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign bus.if_ack_o       = if_ack_q;
  assign bus.if_rdata_o     = if_rdata_q;
  assign bus.dm_ack_o       = dm_ack_q;
  assign bus.dm_rdata_o     = dm_rdata_q;
  assign bus.mem_en_o       = mem_en_q;
  assign bus.mem_we_o       = mem_we_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_wdata_o    = mem_wdata_q;
  assign bus.conflict_cnt_o = conflict_cnt_q;
  assign bus.stall_o        = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the IF/MEM memory port arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1));

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          en_cyc;
  } acc_t;

  acc_t        if_rq[$];
  acc_t        dm_rq[$];
  acc_t        acc_q[$];
  acc_t        ack_q[$];
  int          en_hist[$];
  logic [31:0] mem[logic [31:0]];
  logic        stall_hist[0:4095];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] prev_dm = 32'h0;
  logic [15:0] conf_exp = 16'h0;
  logic        mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_word = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic push_req(input logic is_dm, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output acc_t e);
    e.is_dm = is_dm; e.we = we; e.addr = a; e.wdata = wd;
    e.rdata = we ? 32'h0 : mem_rd(a);
    e.en_cyc = 0;
    if (is_dm) dm_rq.push_back(e); else if_rq.push_back(e);
  endtask

  task automatic drive_ports();
    bus.if_req_i   = (if_rq.size() != 0);
    bus.if_addr_i  = (if_rq.size() != 0) ? if_rq[0].addr : 32'hFFFF_FFF0;
    bus.dm_req_i   = (dm_rq.size() != 0);
    bus.dm_we_i    = (dm_rq.size() != 0) ? dm_rq[0].we : 1'b0;
    bus.dm_addr_i  = (dm_rq.size() != 0) ? dm_rq[0].addr : 32'hFFFF_FFE0;
    bus.dm_wdata_i = (dm_rq.size() != 0) ? dm_rq[0].wdata : 32'hCAFE_0000;
  endtask

  always @(posedge clk) cyc++;

  // Monitor, memory model and requesters, in that order, once per cycle.
  always @(negedge clk) begin : mon
    acc_t e;
    if (!rst) begin
      stall_hist[cyc % 4096] = bus.stall_o;
      check("stall", 64'(bus.stall_o),
            64'((bus.if_req_i & ~bus.if_ack_o) | (bus.dm_req_i & ~bus.dm_ack_o)));
      check("conflict_cnt", 64'(bus.conflict_cnt_o), 64'(conf_exp));
      if (bus.if_req_i && bus.dm_req_i && !bus.if_ack_o && !bus.dm_ack_o) conf_exp++;
      if (bus.mem_en_o) begin
        check("en_while_busy", 64'(ack_q.size()), 64'd0);
        if (acc_q.size() == 0) check("en_spurious", 64'd1, 64'd0);
        else begin
          e = acc_q.pop_front();
          check("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
          check("mem_we", 64'(bus.mem_we_o), 64'(e.we));
          if (e.we) check("mem_wdata", 64'(bus.mem_wdata_o), 64'(e.wdata));
          e.en_cyc = cyc;
          ack_q.push_back(e);
        end
        en_hist.push_back(cyc);
      end
      if (bus.if_ack_o || bus.dm_ack_o) begin
        check("ack_one_hot", 64'(bus.if_ack_o & bus.dm_ack_o), 64'd0);
        if (ack_q.size() == 0) check("ack_spurious", 64'd1, 64'd0);
        else begin
          e = ack_q.pop_front();
          check("ack_port", 64'(bus.dm_ack_o), 64'(e.is_dm));
          check("ack_latency", 64'(cyc - e.en_cyc), 64'(LAT));
          if (!e.is_dm) check("if_rdata", 64'(bus.if_rdata_o), 64'(e.rdata));
          else if (!e.we) begin
            check("dm_rdata", 64'(bus.dm_rdata_o), 64'(e.rdata));
            prev_dm = e.rdata;
          end else check("dm_rdata_keep", 64'(bus.dm_rdata_o), 64'(prev_dm));
        end
        if (bus.if_ack_o && if_rq.size() != 0) if_rq.delete(0);
        if (bus.dm_ack_o && dm_rq.size() != 0) dm_rq.delete(0);
      end
      if (bus.mem_en_o) begin
        mem_pend = 1'b1;
        mem_wait = LAT - 1;
        mem_word = mem_rd(bus.mem_addr_o);
        if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
      end else if (mem_pend) mem_wait--;
      if (mem_pend && mem_wait == 0) begin
        bus.mem_rdata_i = mem_word;
        mem_pend = 1'b0;
      end else bus.mem_rdata_i = 32'hDEAD_BEEF;
      drive_ports();
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    if_rq.delete(); dm_rq.delete(); acc_q.delete(); ack_q.delete();
    mem_pend = 1'b0; conf_exp = 16'h0; prev_dm = 32'h0;
    drive_ports();
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((if_rq.size() != 0 || dm_rq.size() != 0 || acc_q.size() != 0 || ack_q.size() != 0)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 64'({bus.if_ack_o, bus.dm_ack_o, bus.mem_en_o, bus.mem_we_o, bus.stall_o}), 64'd0);
    check({tag, "_addr_wdata"}, {bus.mem_addr_o, bus.mem_wdata_o}, 64'd0);
    check({tag, "_rdata"}, {bus.if_rdata_o, bus.dm_rdata_o}, 64'd0);
    check({tag, "_cnt"}, 64'(bus.conflict_cnt_o), 64'd0);
  endtask

  initial begin : stim
    acc_t e0, e1, e2, e3;
    int s;
    mem[32'h10] = 32'h8C08_0004;
    bus1.if_req_i = 1'b0; bus1.if_addr_i = 32'h0;
    bus1.dm_req_i = 1'b0; bus1.dm_we_i = 1'b0; bus1.dm_addr_i = 32'h0; bus1.dm_wdata_i = 32'h0;
    bus1.mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset, no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("reset");
    end

    // Single fetch
    @(posedge clk); #1;
    s = cyc;
    push_req(1'b0, 1'b0, 32'h10, 32'h0, e0);
    acc_q.push_back(e0);
    drive_ports();
    wait_drain(20);
    check("fetch_en_cyc", 64'(en_hist[$]), 64'(s + 1));
    check("fetch_rdata", 64'(bus.if_rdata_o), 64'h8C08_0004);
    check("fetch_stall", 64'({stall_hist[s % 4096], stall_hist[(s + 1) % 4096],
                              stall_hist[(s + 2) % 4096], stall_hist[(s + 3) % 4096]}), 64'b1110);

    // Both requesting, each dropped in its ack cycle
    @(posedge clk); #1;
    s = cyc;
    push_req(1'b1, 1'b0, 32'h40, 32'h0, e0);
    push_req(1'b0, 1'b0, 32'h44, 32'h0, e1);
    acc_q.push_back(e0); acc_q.push_back(e1);
    drive_ports();
    wait_drain(30);
    check("both_dm_en", 64'(en_hist[en_hist.size() - 2]), 64'(s + 1));
    check("both_if_en", 64'(en_hist[$]), 64'(s + 4));
    check("both_conflicts", 64'(bus.conflict_cnt_o), 64'd3);

    // Both held high continuously
    @(posedge clk); #1;
    s = cyc;
    push_req(1'b1, 1'b0, 32'h100, 32'h0, e0);
    push_req(1'b1, 1'b0, 32'h104, 32'h0, e2);
    push_req(1'b0, 1'b0, 32'h200, 32'h0, e1);
    push_req(1'b0, 1'b0, 32'h204, 32'h0, e3);
    acc_q.push_back(e0); acc_q.push_back(e1); acc_q.push_back(e2); acc_q.push_back(e3);
    drive_ports();
    wait_drain(40);
    check("held_first_en", 64'(en_hist[en_hist.size() - 4]), 64'(s + 1));
    for (int i = en_hist.size() - 3; i < en_hist.size(); i++)
      check("held_en_gap", 64'(en_hist[i] - en_hist[i - 1]), 64'd3);

    // Store then load back
    @(posedge clk); #1;
    push_req(1'b1, 1'b1, 32'h08, 32'h1234_5678, e0);
    acc_q.push_back(e0);
    drive_ports();
    wait_drain(20);
    check("store_keeps_rdata", 64'(bus.dm_rdata_o), 64'(e2.rdata));
    push_req(1'b1, 1'b0, 32'h08, 32'h0, e1);
    e1.rdata = 32'h1234_5678;
    dm_rq[0].rdata = 32'h1234_5678;
    acc_q.push_back(e1);
    drive_ports();
    wait_drain(20);

    // MEM_LAT=1 instance: store, then a held request becomes a load
    @(posedge clk); #1;
    s = cyc;
    bus1.dm_req_i = 1'b1; bus1.dm_we_i = 1'b1; bus1.dm_addr_i = 32'h08;
    bus1.dm_wdata_i = 32'h1234_5678; bus1.mem_rdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    check("l1_store_en", 64'({bus1.mem_en_o, bus1.mem_we_o}), 64'b11);
    check("l1_store_bus", {bus1.mem_addr_o, bus1.mem_wdata_o}, 64'h0000_0008_1234_5678);
    @(negedge clk);
    check("l1_store_ack", 64'({bus1.dm_ack_o, bus1.mem_en_o}), 64'b10);
    check("l1_store_rdata", 64'(bus1.dm_rdata_o), 64'd0);
    bus1.dm_we_i = 1'b0; bus1.dm_addr_i = 32'h20;
    @(negedge clk);
    check("l1_load_en", 64'({bus1.mem_en_o, bus1.mem_we_o, bus1.dm_ack_o}), 64'b100);
    check("l1_load_addr", 64'(bus1.mem_addr_o), 64'h20);
    @(negedge clk);
    check("l1_load_ack", 64'(bus1.dm_ack_o), 64'd1);
    check("l1_load_rdata", 64'(bus1.dm_rdata_o), 64'h0BAD_F00D);
    bus1.dm_req_i = 1'b0;
    @(negedge clk);
    check("l1_quiet", 64'({bus1.dm_ack_o, bus1.mem_en_o}), 64'd0);

    // Reset in the cycle after mem_en_o
    @(posedge clk); #1;
    s = cyc;
    push_req(1'b1, 1'b0, 32'h80, 32'h0, e0);
    acc_q.push_back(e0);
    drive_ports();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_en_seen", 64'(en_hist[$]), 64'(s + 1));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("after_rst");
    end
    @(posedge clk); #1;
    s = cyc;
    push_req(1'b1, 1'b0, 32'h90, 32'h0, e0);
    push_req(1'b0, 1'b0, 32'h94, 32'h0, e1);
    acc_q.push_back(e0); acc_q.push_back(e1);
    drive_ports();
    wait_drain(30);
    check("post_rst_dm_first", 64'(en_hist[en_hist.size() - 2]), 64'(s + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
